uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning baud_tick pulses per bit period (even, >=8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-frame buffer entries (power of 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port baud_tick  input  1  one-clk pulse at OVS x baud rate.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port par_en  input  1  1 = parity bit present.
REQ-008 SHALL have port par_typ  input  1  0 = even, 1 = odd parity.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rd_data  output  8  head-entry data byte, LSB first on the line.
REQ-012 SHALL have port rd_par_err  output  1  head-entry parity mismatch; 0 when par_en was 0.
REQ-013 SHALL have port rd_stop_err  output  1  head-entry stop bit sampled 0.
REQ-014 SHALL have port overrun  output  1  one-clk pulse when a completed frame is dropped because the FIFO is full.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL pass rx_in through a 2-flop synchronizer (reset value 1); all decisions use the synchronized bit.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK; only baud_tick cycles advance the tick counter or change state, except frame push.
REQ-018 IDLE: on a baud_tick with synced rx = 0 -> START, tick counter cleared, par_en/par_typ latched for the whole frame.
REQ-019 START: sample on tick count OVS/2-1; rx = 0 -> DATA, counter cleared; rx = 1 -> IDLE (false start, nothing pushed).
REQ-020 DATA: sample every OVS ticks; bit k (0..7) into data[k]; after bit 7 -> PARITY if latched par_en, else STOP.
REQ-021 PARITY: sample after OVS ticks; par_err = (sample != ^data) for even, (sample != ~^data) for odd.
REQ-022 STOP: sample after OVS ticks; stop_err = ~sample; push {data, par_err, stop_err} on the clk following the sample; -> IDLE if sample 1, else BREAK.
REQ-023 BREAK: stay until a baud_tick with synced rx = 1, then IDLE; no further frames pushed while in BREAK.
REQ-024 FIFO: rd_valid/rd_data/rd_*_err reflect the head entry combinationally; pop when rd_valid & rd_ready.
REQ-025 Push with FIFO full and no pop same cycle -> frame dropped, overrun = 1 for that clk, stored entries unchanged.
REQ-026 Push with FIFO full and pop same cycle -> push accepted, no overrun; simultaneous push/pop at any occupancy leaves count unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-028 Latency: rx_in edge to IDLE->START decision <= 2 clk + 1 baud_tick; stop sample to rd_valid rising (empty FIFO) = 1 clk.

Reset
REQ-029 rst SHALL force state IDLE, counters 0, synchronizer 1, FIFO empty, rd_valid 0, rd_data 0, rd_par_err 0, rd_stop_err 0, overrun 0, busy 0.
REQ-030 rst mid-frame SHALL discard the partial frame; reception restarts only at the next falling start edge after rst release.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state encoding, parity-type constants (PAR_EVEN = 0, PAR_ODD = 1) and default OVS.
REQ-032 The FIFO SHALL be a sub-module uart_rx_fifo (width 10, depth FIFO_DEPTH) with push/pop/full/empty/count.

Verification
REQ-033 par_en=0, frame 0xA5 stop=1, rd_ready=1 -> one entry rd_data=0xA5, errors 0, busy low after stop.
REQ-034 par_en=1, par_typ=1, data 0x3C, parity bit 0 -> rd_data=0x3C, rd_par_err=1; same frame with parity bit 1 -> rd_par_err=0.
REQ-035 rx_in low for 4 baud_ticks then high -> IDLE re-entered, rd_valid stays 0, no push.
REQ-036 rd_ready=0, five frames 0x01..0x05 -> entries 0x01..0x04 held, overrun pulse exactly once on frame 5; draining yields 0x01..0x04.
REQ-037 data 0x55, stop bit 0, line held low 3 bit periods -> rd_stop_err=1, state BREAK until rx high, no extra entries.
REQ-038 rst asserted at data bit 3 of 0xF0, then clean frame 0x81 -> only 0x81 received, errors 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver state encoding, parity-type constants, the default
// oversampling ratio and the layout of one received-frame FIFO entry.
package uart_pkg;

    localparam int unsigned OVS_DEFAULT = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ENTRY_W     = DATA_W + 2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // One received frame as stored in the FIFO; data occupies the MSBs.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par_err;
        logic              stop_err;
    } rx_entry_t;

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic parity_expected(input logic [DATA_W-1:0] d,
                                             input logic              typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-frame buffer: synchronous FIFO, DEPTH entries of WIDTH bits.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties FIFO)
//   push, push_data write request and payload (ignored when full unless
//                   a pop happens in the same cycle)
//   pop             read request (ignored when empty)
//   pop_data        head entry, zero while empty
//   full, empty     occupancy flags
//   count           occupancy, log2(DEPTH)+1 bits
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign count    = cnt;
    assign do_pop   = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are qualified by cnt so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with oversampled bit recovery, optional parity check,
// break detection and a small received-frame FIFO.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   baud_tick      one-clk pulse at OVS x baud rate
//   rx_in          asynchronous serial line, idle high
//   par_en/par_typ parity present / odd(1) or even(0), latched per frame
//   rd_ready       consumer accepts the head entry
//   rd_valid       FIFO non-empty
//   rd_data        head data byte
//   rd_par_err     head parity mismatch (0 when frame had no parity)
//   rd_stop_err    head stop bit sampled low
//   overrun        one-clk pulse when a completed frame is dropped
//   busy           receiver outside IDLE
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OVS        = OVS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_par_err,
    output logic              rd_stop_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(OVS);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVS - 1);

    rx_state_e          state;
    logic               rx_meta;
    logic               rx_sync;
    logic [1:0]         sync_fill;
    logic               armed;
    logic [CNT_W-1:0]   tick_cnt;
    logic [2:0]         bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_err_q;
    logic               push_q;
    rx_entry_t          push_entry;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head_bits;
    logic [FCNT_W-1:0]  fifo_count;
    rx_entry_t          head;

    // Line synchronizer. armed only rises once the real line has been seen
    // high after reset, so a reset released mid-frame waits for a fresh
    // falling start edge instead of decoding the tail of the old frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx_in;
            rx_sync   <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    // Receive FSM; everything except the push strobe advances on baud_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_err_q  <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            push_q <= 1'b0;
            if (baud_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_sync && armed) begin
                            state     <= ST_START;
                            busy      <= 1'b1;
                            tick_cnt  <= '0;
                            par_en_q  <= par_en;
                            par_typ_q <= par_typ;
                            par_err_q <= 1'b0;
                        end
                    end
                    // Confirm the start bit at its midpoint.
                    ST_START: begin
                        if (tick_cnt == MID_CNT) begin
                            tick_cnt <= '0;
                            if (!rx_sync) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt == LAST_CNT) begin
                            tick_cnt       <= '0;
                            shreg[bit_idx] <= rx_sync;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= par_en_q ? ST_PARITY : ST_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt == LAST_CNT) begin
                            tick_cnt  <= '0;
                            par_err_q <= rx_sync ^ parity_expected(shreg, par_typ_q);
                            state     <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    // A low stop bit still delivers the frame, then parks
                    // in BREAK until the line returns high.
                    ST_STOP: begin
                        if (tick_cnt == LAST_CNT) begin
                            tick_cnt   <= '0;
                            push_q     <= 1'b1;
                            push_entry <= '{data: shreg, par_err: par_err_q,
                                            stop_err: ~rx_sync};
                            if (rx_sync) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    ST_BREAK: begin
                        if (rx_sync) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fifo_pop  = rd_ready & ~fifo_empty;
    assign fifo_push = push_q & (~fifo_full | fifo_pop);

    // Dropped frame: full FIFO with no room freed in the push cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push_q & fifo_full & ~fifo_pop;
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head        = fifo_head_bits;
    assign rd_valid    = (fifo_count != '0);
    assign rd_data     = head.data;
    assign rd_par_err  = head.par_err;
    assign rd_stop_err = head.stop_err;

endmodule
